// File: rtl/psum_in_bus_ctrl.sv
// psum_in_bus_ctrl
//
// Sequencer for the shared psum-in row bus that feeds a row of psum-in routers.
// A pass walks pe_num consecutive destination IDs, starting at start_id. For each
// ID the controller:
//   1. drives source_id,
//   2. waits for the addressed PE to raise pe_ready,
//   3. streams burst_len psum beats from an upstream valid/ready source onto the bus.
// done pulses for one cycle after the last PE of the range has received its burst.
//
// Ports
//   clk, rst_n       clock and synchronous active-low reset
//   config_state, ce configuration write strobe (taken only while idle)
//   cfg_start_id     first destination ID
//   cfg_pe_num       number of PEs served per pass
//   cfg_burst_len    psum beats per PE
//   start            one-cycle pulse that launches a pass
//   abort            synchronous abort of the current pass
//   src_data         upstream psum data
//   src_valid        upstream data valid
//   src_ready        upstream handshake acceptance
//   pe_ready         wired-OR of the routers' ready; only the addressed router drives it
//   source_id        ID currently addressed on the bus
//   bus_data_out     psum data broadcast to the routers (zero when not valid)
//   bus_data_valid   bus data valid
//   busy             high while a pass is in progress (WAIT or SEND)
//   done             one-cycle end-of-pass pulse
module psum_in_bus_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  config_state,
    input  logic                  ce,
    input  logic [ID_WIDTH-1:0]   cfg_start_id,
    input  logic [ID_WIDTH-1:0]   cfg_pe_num,
    input  logic [LEN_WIDTH-1:0]  cfg_burst_len,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic                  pe_ready,
    output logic [ID_WIDTH-1:0]   source_id,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_data_valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StSend,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   start_id_q, start_id_d;
    logic [ID_WIDTH-1:0]   pe_num_q, pe_num_d;
    logic [LEN_WIDTH-1:0]  burst_len_q, burst_len_d;
    logic [ID_WIDTH-1:0]   cur_id_q, cur_id_d;
    logic [ID_WIDTH-1:0]   pe_cnt_q, pe_cnt_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

    logic cfg_wr;
    logic send_ok;
    logic xfer;
    logic last_beat;
    logic last_pe;

    // Configuration is only accepted while idle, so the registers cannot change
    // under a running pass.
    assign cfg_wr = config_state && ce && (state_q == StIdle);

    // abort wins over any transfer in the same cycle, so no beat is consumed.
    assign send_ok   = (state_q == StSend) && !abort;
    assign xfer      = send_ok && src_valid && pe_ready;

    // burst_len and pe_num are non-zero whenever SEND is reachable, so the
    // subtractions below never underflow in a cycle where they matter.
    assign last_beat = (beat_cnt_q == (burst_len_q - LEN_WIDTH'(1)));
    assign last_pe   = (pe_cnt_q == (pe_num_q - ID_WIDTH'(1)));

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        start_id_d  = start_id_q;
        pe_num_d    = pe_num_q;
        burst_len_d = burst_len_q;
        cur_id_d    = cur_id_q;
        pe_cnt_d    = pe_cnt_q;
        beat_cnt_d  = beat_cnt_q;

        if (cfg_wr) begin
            start_id_d  = cfg_start_id;
            pe_num_d    = cfg_pe_num;
            burst_len_d = cfg_burst_len;
        end

        case (state_q)
            StIdle: begin
                // A config write in the same cycle takes priority over start.
                if (start && !cfg_wr) begin
                    if ((pe_num_q != '0) && (burst_len_q != '0)) begin
                        state_d    = StWait;
                        cur_id_d   = start_id_q;
                        pe_cnt_d   = '0;
                        beat_cnt_d = '0;
                    end else begin
                        // Empty pass: report completion without touching the bus.
                        state_d = StDone;
                    end
                end
            end

            StWait: begin
                if (abort) begin
                    state_d    = StIdle;
                    pe_cnt_d   = '0;
                    beat_cnt_d = '0;
                end else if (pe_ready) begin
                    state_d = StSend;
                end
            end

            StSend: begin
                if (abort) begin
                    state_d    = StIdle;
                    pe_cnt_d   = '0;
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    if (last_beat) begin
                        if (last_pe) begin
                            state_d = StDone;
                        end else begin
                            state_d    = StWait;
                            cur_id_d   = cur_id_q + ID_WIDTH'(1); // wraps mod 2^ID_WIDTH
                            pe_cnt_d   = pe_cnt_q + ID_WIDTH'(1);
                            beat_cnt_d = '0;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    end
                end
                // pe_ready low or src_valid low: stall, beat_cnt held.
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            start_id_q  <= '0;
            pe_num_q    <= '0;
            burst_len_q <= '0;
            cur_id_q    <= '0;
            pe_cnt_q    <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            start_id_q  <= start_id_d;
            pe_num_q    <= pe_num_d;
            burst_len_q <= burst_len_d;
            cur_id_q    <= cur_id_d;
            pe_cnt_q    <= pe_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // Outputs
    always_comb begin
        src_ready      = send_ok && pe_ready;
        bus_data_valid = xfer;
        bus_data_out   = xfer ? src_data : '0;
        busy           = (state_q == StWait) || (state_q == StSend);
        done           = (state_q == StDone);
        source_id      = cur_id_q;
    end

endmodule

// File: tb/tb_psum_in_bus_ctrl.sv
// Directed bench for psum_in_bus_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are checked 1 unit later, well away from the next edge.
// "cycle k" below means the k-th cycle after the edge that sampled start.
module tb_psum_in_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        config_state;
    logic        ce;
    logic [7:0]  cfg_start_id;
    logic [7:0]  cfg_pe_num;
    logic [7:0]  cfg_burst_len;
    logic        start;
    logic        abort;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        pe_ready;
    logic [7:0]  source_id;
    logic [15:0] bus_data_out;
    logic        bus_data_valid;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    psum_in_bus_ctrl #(
        .DATA_WIDTH (16),
        .ID_WIDTH   (8),
        .LEN_WIDTH  (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .config_state   (config_state),
        .ce             (ce),
        .cfg_start_id   (cfg_start_id),
        .cfg_pe_num     (cfg_pe_num),
        .cfg_burst_len  (cfg_burst_len),
        .start          (start),
        .abort          (abort),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .pe_ready       (pe_ready),
        .source_id      (source_id),
        .bus_data_out   (bus_data_out),
        .bus_data_valid (bus_data_valid),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_config(input logic [7:0] sid, input logic [7:0] num, input logic [7:0] len);
        config_state  = 1'b1;
        ce            = 1'b1;
        cfg_start_id  = sid;
        cfg_pe_num    = num;
        cfg_burst_len = len;
        tick();
        config_state  = 1'b0;
        ce            = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits up to n cycles for done; leaves time in the done cycle if seen.
    task automatic wait_done(input string tag, input int n);
        logic found;
        found = 1'b0;
        for (int i = 0; i < n; i++) begin
            settle();
            if (done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int   idx;
        logic got_done;
        logic exp_v;

        rst_n = 1'b0; config_state = 1'b0; ce = 1'b0;
        cfg_start_id = 8'h00; cfg_pe_num = 8'h00; cfg_burst_len = 8'h00;
        start = 1'b0; abort = 1'b0; src_data = 16'hdead; src_valid = 1'b1; pe_ready = 1'b1;
        tick();
        tick();
        settle();
        // Reset state: all outputs zero even with src_valid/pe_ready high.
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_source_id", 32'(source_id), 32'd0);
        check("rst_src_ready", 32'(src_ready), 32'd0);
        check("rst_valid", 32'(bus_data_valid), 32'd0);
        check("rst_data", 32'(bus_data_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // --- Basic pass: start_id 3, 2 PEs, 4 beats, everything ready ---
        do_config(8'd3, 8'd2, 8'd4);
        do_start();
        for (int k = 1; k <= 12; k++) begin
            src_data = 16'(16'h0100 + k);
            settle();
            exp_v = ((k >= 2) && (k <= 5)) || ((k >= 7) && (k <= 10));
            check("p1_busy", 32'(busy), 32'((k <= 10) ? 1 : 0));
            check("p1_done", 32'(done), 32'((k == 11) ? 1 : 0));
            check("p1_source_id", 32'(source_id), (k <= 5) ? 32'd3 : 32'd4);
            check("p1_valid", 32'(bus_data_valid), 32'(exp_v));
            check("p1_data", 32'(bus_data_out), exp_v ? 32'(src_data) : 32'd0);
            tick();
        end

        // --- pe_ready toggling in SEND; 8 ordered values 0x10..0x17 ---
        do_start();
        idx = 0;
        got_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            pe_ready = ~c[0];
            src_data = 16'(16'h0010 + idx);
            settle();
            if (!pe_ready) check("tog_valid_when_not_ready", 32'(bus_data_valid), 32'd0);
            if (bus_data_valid) begin
                check("tog_data", 32'(bus_data_out), 32'(16'h0010 + idx));
                check("tog_source_id", 32'(source_id), (idx < 4) ? 32'd3 : 32'd4);
                idx++;
            end
            if (done) begin
                got_done = 1'b1;
                tick();
                break;
            end
            tick();
        end
        check("tog_beats", 32'(idx), 32'd8);
        check("tog_done_seen", 32'(got_done), 32'd1);
        pe_ready = 1'b1;

        // --- src_valid gap of 3 cycles mid-burst ---
        src_valid = 1'b1;
        do_start();
        tick();                                   // cycle 1: WAIT
        for (int k = 2; k <= 8; k++) begin
            src_valid = ((k >= 4) && (k <= 6)) ? 1'b0 : 1'b1;
            src_data  = 16'(16'h0200 + k);
            settle();
            check("gap_src_ready", 32'(src_ready), 32'd1);
            check("gap_valid", 32'(bus_data_valid), 32'(src_valid));
            if (!src_valid) check("gap_data_zero", 32'(bus_data_out), 32'd0);
            tick();
        end
        src_valid = 1'b1;
        settle();
        // Four beats taken despite the gap: now in WAIT for PE 4.
        check("gap_next_pe", 32'(source_id), 32'd4);
        check("gap_wait_valid", 32'(bus_data_valid), 32'd0);
        check("gap_wait_busy", 32'(busy), 32'd1);
        wait_done("gap_done_seen", 20);
        tick();

        // --- Config write and start in the same cycle: start ignored ---
        config_state = 1'b1; ce = 1'b1; start = 1'b1;
        cfg_start_id = 8'd3; cfg_pe_num = 8'd2; cfg_burst_len = 8'd4;
        tick();
        config_state = 1'b0; ce = 1'b0; start = 1'b0;
        settle();
        check("cfgstart_busy", 32'(busy), 32'd0);
        check("cfgstart_done", 32'(done), 32'd0);
        tick();

        // --- pe_num = 0: immediate done, no bus activity ---
        do_config(8'd9, 8'd0, 8'd4);
        do_start();
        settle();
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_valid", 32'(bus_data_valid), 32'd0);
        check("zero_src_ready", 32'(src_ready), 32'd0);
        tick();
        settle();
        check("zero_done_clear", 32'(done), 32'd0);
        check("zero_busy_after", 32'(busy), 32'd0);

        // --- ID wrap 0xFF -> 0x00, burst_len 1; writes during busy/DONE ignored ---
        do_config(8'hFF, 8'd2, 8'd1);
        do_start();
        settle();
        check("wrap_c1_id", 32'(source_id), 32'hFF);
        check("wrap_c1_valid", 32'(bus_data_valid), 32'd0);
        config_state = 1'b1; ce = 1'b1;
        cfg_start_id = 8'h55; cfg_pe_num = 8'd7; cfg_burst_len = 8'd3;
        tick();
        settle();
        check("wrap_c2_valid", 32'(bus_data_valid), 32'd1);
        check("wrap_c2_id", 32'(source_id), 32'hFF);
        tick();
        settle();
        check("wrap_c3_id", 32'(source_id), 32'h00);
        check("wrap_c3_valid", 32'(bus_data_valid), 32'd0);
        tick();
        settle();
        check("wrap_c4_valid", 32'(bus_data_valid), 32'd1);
        tick();
        settle();
        check("wrap_c5_done", 32'(done), 32'd1);
        tick();
        config_state = 1'b0; ce = 1'b0;
        settle();
        check("wrap_id_held", 32'(source_id), 32'h00);
        check("wrap_idle_busy", 32'(busy), 32'd0);
        do_start();
        settle();
        check("wrap_cfg_kept", 32'(source_id), 32'hFF);
        wait_done("wrap_rerun_done", 10);
        tick();

        // --- abort on the 2nd beat of PE 0, then a 2-beat pass ---
        do_config(8'd3, 8'd2, 8'd4);
        do_start();
        tick();                                   // cycle 1: WAIT
        src_data = 16'hAAAA;
        settle();
        check("abort_beat1", 32'(bus_data_valid), 32'd1);
        tick();
        abort = 1'b1;
        src_data = 16'hBBBB;
        settle();
        check("abort_src_ready", 32'(src_ready), 32'd0);
        check("abort_valid", 32'(bus_data_valid), 32'd0);
        check("abort_data", 32'(bus_data_out), 32'd0);
        tick();
        abort = 1'b0;
        settle();
        check("abort_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            settle();
            check("abort_no_done", 32'(done), 32'd0);
            tick();
        end
        do_config(8'd3, 8'd2, 8'd2);
        do_start();
        for (int k = 1; k <= 7; k++) begin
            src_data = 16'(16'h0300 + k);
            settle();
            exp_v = (k == 2) || (k == 3) || (k == 5) || (k == 6);
            check("p6_source_id", 32'(source_id), (k <= 3) ? 32'd3 : 32'd4);
            check("p6_valid", 32'(bus_data_valid), 32'(exp_v));
            check("p6_done", 32'(done), 32'((k == 7) ? 1 : 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
